// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the memory.
// slave: arbiter side; master: requester/memory side.
interface mem_arbiter_if #(
  parameter int AW    = 10,
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             ls_req;
  logic             ls_we;
  logic [AW-1:0]    ls_addr;
  logic [WIDTH-1:0] ls_wdata;
  logic             ls_gnt;
  logic             ls_rvalid;
  logic [WIDTH-1:0] ls_rdata;
  logic             mem_re;
  logic             mem_we;
  logic [AW-1:0]    mem_raddr;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_re, mem_we, mem_raddr,
    output mem_waddr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_re, mem_we, mem_raddr,
    input  mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// IF/LS arbiter for one single-port memory (clk, rst, bus slave).
// MEM_ARB_RR_EN selects round-robin ties instead of LS priority.
module mem_arbiter #(
  parameter int  DEPTH   = 1024,
  parameter int  WIDTH   = 32,
  parameter int  LATENCY = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;
  localparam bit   ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAST =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [3:0]       r_lat_cnt;
  logic [3:0]       w_nxt_cnt;
  logic             r_owner;
  logic             w_nxt_owner;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    w_nxt_addr;
  logic             w_ls_win;
  logic             w_if_win;
  logic [WIDTH-1:0] w_rdata;

  assign w_rdata = bus.mem_rdata;

`ifdef MEM_ARB_RR_EN
  logic r_last;
  logic w_nxt_last;

  // Tie goes to whoever did not win last time.
  assign w_ls_win = bus.ls_req &
    (~bus.if_req | (r_last == OWN_IF));
`else
  assign w_ls_win = bus.ls_req;
`endif
  assign w_if_win = bus.if_req & ~w_ls_win;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_lat_cnt;
    w_nxt_owner   = r_owner;
    w_nxt_addr    = r_addr;
`ifdef MEM_ARB_RR_EN
    w_nxt_last    = r_last;
`endif
    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_gnt    = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    // Outputs stay quiet while reset is held.
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_ls_win: begin
              bus.ls_gnt = 1'b1;
`ifdef MEM_ARB_RR_EN
              w_nxt_last = OWN_LS;
`endif
              if (bus.ls_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = bus.ls_addr;
                bus.mem_wdata = bus.ls_wdata;
              end else begin
                bus.mem_re    = 1'b1;
                bus.mem_raddr = bus.ls_addr;
                if (ZERO_LAT) begin
                  bus.ls_rvalid = 1'b1;
                  bus.ls_rdata  = w_rdata;
                end else begin
                  w_nxt_state = RD_WAIT;
                  w_nxt_cnt   = '0;
                  w_nxt_owner = OWN_LS;
                  w_nxt_addr  = bus.ls_addr;
                end
              end
            end
            w_if_win: begin
              bus.if_gnt    = 1'b1;
`ifdef MEM_ARB_RR_EN
              w_nxt_last    = OWN_IF;
`endif
              bus.mem_re    = 1'b1;
              bus.mem_raddr = bus.if_addr;
              if (ZERO_LAT) begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = w_rdata;
              end else begin
                w_nxt_state = RD_WAIT;
                w_nxt_cnt   = '0;
                w_nxt_owner = OWN_IF;
                w_nxt_addr  = bus.if_addr;
              end
            end
            default: ;
          endcase
        end
        RD_WAIT: begin
          // Address held from the grant cycle.
          bus.mem_re    = 1'b1;
          bus.mem_raddr = r_addr;
          if (r_lat_cnt == LAST) begin
            // Counter saturates; retry until ready.
            if (bus.mem_ready) begin
              w_nxt_state = IDLE;
              if (r_owner == OWN_LS) begin
                bus.ls_rvalid = 1'b1;
                bus.ls_rdata  = w_rdata;
              end else begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = w_rdata;
              end
            end
          end else begin
            w_nxt_cnt = r_lat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_owner   <= OWN_IF;
      r_addr    <= '0;
`ifdef MEM_ARB_RR_EN
      r_last    <= OWN_IF;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_lat_cnt <= w_nxt_cnt;
      r_owner   <= w_nxt_owner;
      r_addr    <= w_nxt_addr;
`ifdef MEM_ARB_RR_EN
      r_last    <= w_nxt_last;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand sequences, random vs model.
// Two instances: LATENCY=0 and LATENCY=3.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int W  = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [W-1:0]  ls_wdata;
    logic          rdy;
  } in_t;

  typedef struct packed {
    logic          if_gnt;
    logic          if_rvalid;
    logic [W-1:0]  if_rdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [W-1:0]  ls_rdata;
    logic          re;
    logic          we;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
  } out_t;

  typedef struct {
    logic r;
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3, minit;
  int vectors, miscompares;

  mem_arbiter_if #(.AW(AW), .WIDTH(W)) ifc0();
  mem_arbiter_if #(.AW(AW), .WIDTH(W)) ifc3();

  mem_arbiter #(.DEPTH(1024), .WIDTH(W), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .bus(ifc0.slave));
  mem_arbiter #(.DEPTH(1024), .WIDTH(W), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .bus(ifc3.slave));

  function automatic logic [W-1:0] init(input logic [AW-1:0] a);
    return (a == 10'd5) ? 32'hDEADBEEF : 32'h5A5A0000 + {22'd0, a};
  endfunction

  logic [W-1:0] mem0 [1024];
  logic [W-1:0] mem3 [1024];

  always @(posedge clk) begin
    if (minit) begin
      for (int k = 0; k < 1024; k++) begin
        mem0[k] <= init(k[9:0]);
        mem3[k] <= init(k[9:0]);
      end
    end else begin
      if (ifc0.mem_we) mem0[ifc0.mem_waddr] <= ifc0.mem_wdata;
      if (ifc3.mem_we) mem3[ifc3.mem_waddr] <= ifc3.mem_wdata;
    end
  end

  assign ifc0.mem_rdata = mem0[ifc0.mem_raddr];
  assign ifc3.mem_rdata = mem3[ifc3.mem_raddr];

  function automatic in_t vin(logic ir, logic [AW-1:0] ia,
      logic lr, logic lw, logic [AW-1:0] la,
      logic [W-1:0] ld, logic rd);
    in_t v;
    v.if_req = ir; v.if_addr = ia;
    v.ls_req = lr; v.ls_we = lw;
    v.ls_addr = la; v.ls_wdata = ld;
    v.rdy = rd;
    return v;
  endfunction

  function automatic out_t vout(logic ig, logic iv,
      logic [W-1:0] id, logic lg, logic lv, logic [W-1:0] ld,
      logic re, logic we, logic [AW-1:0] ra,
      logic [AW-1:0] wa, logic [W-1:0] wd);
    out_t o;
    o.if_gnt = ig; o.if_rvalid = iv; o.if_rdata = id;
    o.ls_gnt = lg; o.ls_rvalid = lv; o.ls_rdata = ld;
    o.re = re; o.we = we;
    o.raddr = ra; o.waddr = wa; o.wdata = wd;
    return o;
  endfunction

  task automatic drive(input int d, input logic r, input in_t v);
    if (d == 0) begin
      rst0 = r;
      ifc0.if_req = v.if_req;   ifc0.if_addr = v.if_addr;
      ifc0.ls_req = v.ls_req;   ifc0.ls_we = v.ls_we;
      ifc0.ls_addr = v.ls_addr; ifc0.ls_wdata = v.ls_wdata;
      ifc0.mem_ready = v.rdy;
    end else begin
      rst3 = r;
      ifc3.if_req = v.if_req;   ifc3.if_addr = v.if_addr;
      ifc3.ls_req = v.ls_req;   ifc3.ls_we = v.ls_we;
      ifc3.ls_addr = v.ls_addr; ifc3.ls_wdata = v.ls_wdata;
      ifc3.mem_ready = v.rdy;
    end
  endtask

  function automatic out_t sample(input int d);
    out_t o;
    if (d == 0) begin
      o = vout(ifc0.if_gnt, ifc0.if_rvalid, ifc0.if_rdata,
        ifc0.ls_gnt, ifc0.ls_rvalid, ifc0.ls_rdata,
        ifc0.mem_re, ifc0.mem_we, ifc0.mem_raddr,
        ifc0.mem_waddr, ifc0.mem_wdata);
    end else begin
      o = vout(ifc3.if_gnt, ifc3.if_rvalid, ifc3.if_rdata,
        ifc3.ls_gnt, ifc3.ls_rvalid, ifc3.ls_rdata,
        ifc3.mem_re, ifc3.mem_we, ifc3.mem_raddr,
        ifc3.mem_waddr, ifc3.mem_wdata);
    end
    return o;
  endfunction

  task automatic check(input string nm, input out_t got,
      input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input int d, input logic r, input in_t v,
      input out_t e, input string nm);
    drive(d, r, v);
    @(negedge clk);
    check(nm, sample(d), e);
    @(posedge clk);
    #1;
  endtask

  // Reference model: one pending read at most, counted in
  // whole cycles since the grant; ties by priority or RR.
  logic         m_busy [2];
  logic         m_own  [2];
  logic         m_lw   [2];
  logic [AW-1:0] m_ha  [2];
  int           m_el   [2];
  logic [W-1:0] rmem   [2][1024];
  in_t          cur    [2];

  task automatic rd(input int d, input int L, input logic own,
      input logic [AW-1:0] a, inout out_t e);
    e.re = 1'b1;
    e.raddr = a;
    if (L == 0) begin
      if (own) begin
        e.ls_rvalid = 1'b1; e.ls_rdata = rmem[d][a];
      end else begin
        e.if_rvalid = 1'b1; e.if_rdata = rmem[d][a];
      end
    end else begin
      m_busy[d] = 1'b1; m_own[d] = own;
      m_ha[d] = a; m_el[d] = 0;
    end
  endtask

  task automatic model(input int d, input logic r, input in_t v,
      output out_t e);
    int   L;
    logic lsw;
    L = (d == 0) ? 0 : 3;
    e = '0;
    if (r) begin
      m_busy[d] = 1'b0; m_lw[d] = 1'b0; m_el[d] = 0;
      return;
    end
    if (m_busy[d]) begin
      m_el[d]++;
      e.re = 1'b1;
      e.raddr = m_ha[d];
      if (m_el[d] >= L && v.rdy) begin
        m_busy[d] = 1'b0;
        if (m_own[d]) begin
          e.ls_rvalid = 1'b1; e.ls_rdata = rmem[d][m_ha[d]];
        end else begin
          e.if_rvalid = 1'b1; e.if_rdata = rmem[d][m_ha[d]];
        end
      end
      return;
    end
    lsw = v.ls_req && (!v.if_req || !RR || m_lw[d] == 1'b0);
    if (lsw) begin
      e.ls_gnt = 1'b1;
      m_lw[d] = 1'b1;
      if (v.ls_we) begin
        e.we = 1'b1; e.waddr = v.ls_addr; e.wdata = v.ls_wdata;
        rmem[d][v.ls_addr] = v.ls_wdata;
      end else begin
        rd(d, L, 1'b1, v.ls_addr, e);
      end
    end else if (v.if_req) begin
      e.if_gnt = 1'b1;
      m_lw[d] = 1'b0;
      rd(d, L, 1'b0, v.if_addr, e);
    end
  endtask

  // Requesters hold until granted, then pick a fresh request.
  task automatic gen(input int d, input out_t e);
    in_t c;
    c = cur[d];
    if (!c.if_req || e.if_gnt) begin
      c.if_req  = ($urandom_range(0, 2) != 0);
      c.if_addr = 10'($urandom_range(0, 15));
    end else if ($urandom_range(0, 3) == 0) begin
      c.if_addr = 10'($urandom_range(0, 15));
    end
    if (!c.ls_req || e.ls_gnt) begin
      c.ls_req   = ($urandom_range(0, 2) != 0);
      c.ls_we    = 1'($urandom_range(0, 1));
      c.ls_addr  = 10'($urandom_range(0, 15));
      c.ls_wdata = $urandom;
    end else if ($urandom_range(0, 3) == 0) begin
      c.ls_addr = 10'($urandom_range(0, 15));
    end
    c.rdy = ($urandom_range(0, 3) != 0);
    cur[d] = c;
  endtask

  vec_t tbl [11];
  in_t  idle, both;
  out_t z, ls2, if3;
  out_t ex [2];
  logic rr;

  initial begin
    vectors = 0;
    miscompares = 0;
    idle = vin(0, 0, 0, 0, 0, 0, 1);
    both = vin(1, 3, 1, 0, 2, 0, 1);
    z    = '0;
    ls2  = vout(0, 0, 0, 1, 1, 32'h5A5A0002, 1, 0, 2, 0, 0);
    if3  = vout(1, 1, 32'h5A5A0003, 0, 0, 0, 1, 0, 3, 0, 0);

    tbl[0]  = '{1'b1, vin(1, 5, 0, 0, 0, 0, 1), z};
    tbl[1]  = '{1'b0, idle, z};
    tbl[2]  = '{1'b0, vin(1, 5, 0, 0, 0, 0, 1),
      vout(1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 5, 0, 0)};
    tbl[3]  = '{1'b0, vin(0, 0, 1, 1, 7, 32'h12345678, 1),
      vout(0, 0, 0, 1, 0, 0, 0, 1, 0, 7, 32'h12345678)};
    tbl[4]  = '{1'b0, vin(0, 0, 1, 0, 7, 0, 1),
      vout(0, 0, 0, 1, 1, 32'h12345678, 1, 0, 7, 0, 0)};
    tbl[5]  = '{1'b0, both, RR ? if3 : ls2};
    tbl[6]  = '{1'b0, both, ls2};
    tbl[7]  = '{1'b0, both, RR ? if3 : ls2};
    tbl[8]  = '{1'b0, vin(1, 3, 1, 1, 9, 32'hCAFEF00D, 1),
      vout(0, 0, 0, 1, 0, 0, 0, 1, 0, 9, 32'hCAFEF00D)};
    tbl[9]  = '{1'b0, vin(1, 9, 0, 0, 0, 0, 1),
      vout(1, 1, 32'hCAFEF00D, 0, 0, 0, 1, 0, 9, 0, 0)};
    tbl[10] = '{1'b0, vin(0, 9, 0, 0, 4, 0, 1), z};

    minit = 1'b1;
    drive(0, 1'b1, idle);
    drive(1, 1'b1, idle);
    @(posedge clk);
    #1;
    minit = 1'b0;

    for (int n = 0; n < 11; n++)
      step(0, tbl[n].r, tbl[n].i, tbl[n].o,
        $sformatf("tbl[%0d]", n));

    step(0, 1'b1, idle, z, "tie_rst");
    for (int n = 0; n < 4; n++)
      step(0, 1'b0, both, (RR && n % 2 == 1) ? if3 : ls2,
        $sformatf("tie[%0d]", n));

    // LATENCY=3: hold, rvalid at T+3, LS waits until T+4.
    step(1, 1'b1, idle, z, "l3_rst");
    step(1, 1'b0, vin(1, 9, 0, 0, 0, 0, 1),
      vout(1, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0), "l3_T");
    step(1, 1'b0, vin(0, 33, 1, 0, 4, 0, 1),
      vout(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0), "l3_T1");
    step(1, 1'b0, vin(0, 33, 1, 0, 4, 0, 1),
      vout(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0), "l3_T2");
    step(1, 1'b0, vin(0, 33, 1, 0, 4, 0, 1),
      vout(0, 1, 32'h5A5A0009, 0, 0, 0, 1, 0, 9, 0, 0), "l3_T3");
    step(1, 1'b0, vin(0, 33, 1, 0, 4, 0, 1),
      vout(0, 0, 0, 1, 0, 0, 1, 0, 4, 0, 0), "l3_T4");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0), "l3_T5");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0), "l3_T6");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 1, 32'h5A5A0004, 1, 0, 4, 0, 0), "l3_T7");

    // Reset mid-read abandons the access.
    step(1, 1'b0, vin(1, 9, 0, 0, 0, 0, 1),
      vout(1, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0), "rstmid_T");
    step(1, 1'b1, idle, z, "rstmid_T1");
    step(1, 1'b0, idle, z, "rstmid_T2");
    step(1, 1'b0, vin(1, 6, 0, 0, 0, 0, 1),
      vout(1, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0), "rstmid_T3");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0), "rstmid_T4");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0), "rstmid_T5");
    step(1, 1'b0, idle,
      vout(1'b0, 1, 32'h5A5A0006, 0, 0, 0, 1, 0, 6, 0, 0),
      "rstmid_T6");

    // mem_ready low at the latency point stretches the read.
    step(1, 1'b0, vin(1, 8, 0, 0, 0, 0, 1),
      vout(1, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0), "stall_T");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0), "stall_T1");
    step(1, 1'b0, idle,
      vout(0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0), "stall_T2");
    step(1, 1'b0, vin(0, 0, 0, 0, 0, 0, 0),
      vout(0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0), "stall_T3");
    step(1, 1'b0, vin(0, 0, 0, 0, 0, 0, 0),
      vout(0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0), "stall_T4");
    step(1, 1'b0, idle,
      vout(0, 1, 32'h5A5A0008, 0, 0, 0, 1, 0, 8, 0, 0),
      "stall_T5");
    step(1, 1'b0, idle, z, "stall_T6");

    // Random traffic on both instances against the model.
    for (int d = 0; d < 2; d++) begin
      cur[d] = '0;
      for (int k = 0; k < 1024; k++) rmem[d][k] = init(k[9:0]);
    end
    for (int n = 0; n < 600; n++) begin
      rr = (n < 2);
      minit = (n == 0);
      drive(0, rr, cur[0]);
      drive(1, rr, cur[1]);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        model(d, rr, cur[d], ex[d]);
        check($sformatf("rand_u%0d[%0d]", d, n), sample(d), ex[d]);
        gen(d, ex[d]);
      end
      @(posedge clk);
      #1;
    end
    minit = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
